// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: operand width,
// funct3 operation encodings and the control FSM states.
package muldiv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_div_iter.sv
// Restoring unsigned divider, one quotient bit per step. Operates on
// magnitudes; sign correction is done by the parent. The next-step quotient
// and remainder are exported so the parent can capture the final step's
// result on the same edge that ends the operation.
module muldiv_div_iter #(
  parameter int XLEN = muldiv_pkg::XLEN
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_load,
  input  logic            i_step,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_quo_d,
  output logic [XLEN-1:0] o_rem_d
);

  logic [XLEN-1:0] quo_q, rem_q, dsor_q;
  logic [XLEN:0]   rem_shift, diff;
  logic            diff_unused;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // NOTE: every output of a combinational block is assigned on every path so no latch is inferred.
  always_comb begin
    rem_shift = {rem_q, quo_q[XLEN-1]};
    diff      = rem_shift - {1'b0, dsor_q};
    if (rem_shift >= {1'b0, dsor_q}) begin
      o_rem_d = diff[XLEN-1:0];
      o_quo_d = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      o_rem_d = rem_shift[XLEN-1:0];
      o_quo_d = {quo_q[XLEN-2:0], 1'b0};
    end
  end

  // After a successful subtract the difference is below the divisor, so its top bit is always zero.
  assign diff_unused = diff[XLEN];

  // Divider state: the quotient register starts as the dividend and fills with quotient bits.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dsor_q <= '0;
    end else if (i_load) begin
      quo_q  <= i_dividend;
      rem_q  <= '0;
      dsor_q <= i_divisor;
    end else if (i_step) begin
      quo_q <= o_quo_d;
      rem_q <= o_rem_d;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit with IDLE/BUSY/DONE handshake. Multiplies use a
// 32-step shift-add datapath; divides use muldiv_div_iter (32 steps). Both
// work on operand magnitudes with a final sign fix-up.
// Build option: define MULDIV_FAST_MUL_EN to compute multiplies in a single
// BUSY cycle; divide latency is unaffected.
module muldiv_unit #(
  parameter int XLEN = muldiv_pkg::XLEN
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_rs1_val,
  input  logic [XLEN-1:0] i_rs2_val,
  input  logic [4:0]      i_rd,
  output logic            o_ready,
  output logic            o_done,
  output logic [4:0]      rd,
  output logic            rd_write_control,
  output logic [XLEN-1:0] rd_write_val
);
  import muldiv_pkg::*;

  localparam int CNT_W = $clog2(XLEN);

  state_e            state_q, state_d;
  op_e               op_in, op_q;
  logic [4:0]        rd_q, rd_out_q;
  logic [XLEN-1:0]   res_q, mcand_q, result_d;
  logic [2*XLEN-1:0] prod_q, mul_final, mul_signed;
  logic [CNT_W-1:0]  cnt_q;
  logic              neg_q, rem_neg_q, div_zero_q;
  logic              accept, last_step;
  logic              a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag, quo_d, rem_d, quo_fix, rem_fix, mul_res, div_res;

  assign op_in  = op_e'(i_op);
  assign accept = (state_q == IDLE) && i_valid;

  // Operand signedness and magnitudes for the incoming request.
  always_comb begin
    a_sgn = (op_in == OP_MULH) || (op_in == OP_MULHSU) || (op_in == OP_DIV) || (op_in == OP_REM);
    b_sgn = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
    a_neg = a_sgn & i_rs1_val[XLEN-1];
    b_neg = b_sgn & i_rs2_val[XLEN-1];
    a_mag = a_neg ? -i_rs1_val : i_rs1_val;
    b_mag = b_neg ? -i_rs2_val : i_rs2_val;
  end

`ifdef MULDIV_FAST_MUL_EN
  // Single-cycle product; multiplies finish on their first BUSY edge.
  always_comb begin
    mul_final = {{XLEN{1'b0}}, mcand_q} * {{XLEN{1'b0}}, prod_q[XLEN-1:0]};
    last_step = (state_q == BUSY) && (!op_q[2] || cnt_q == CNT_W'(XLEN - 1));
  end
`else
  logic [XLEN:0] mul_sum;

  // Shift-add step: add the multiplicand into the high half when the multiplier LSB is set.
  always_comb begin
    mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    mul_final = {mul_sum, prod_q[XLEN-1:1]};
    last_step = (state_q == BUSY) && (cnt_q == CNT_W'(XLEN - 1));
  end
`endif

  // Sign fix-up and result selection from the values produced by the final step.
  always_comb begin
    mul_signed = neg_q ? -mul_final : mul_final;
    mul_res    = (op_q == OP_MUL) ? mul_signed[XLEN-1:0] : mul_signed[2*XLEN-1:XLEN];
    quo_fix    = div_zero_q ? '1 : (neg_q ? -quo_d : quo_d);
    rem_fix    = rem_neg_q ? -rem_d : rem_d;
    div_res    = op_q[1] ? rem_fix : quo_fix;
    result_d   = op_q[2] ? div_res : mul_res;
  end

  muldiv_div_iter #(.XLEN(XLEN)) u_div (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (accept),
    .i_step     ((state_q == BUSY) && op_q[2]),
    .i_dividend (a_mag),
    .i_divisor  (b_mag),
    .o_quo_d    (quo_d),
    .o_rem_d    (rem_d)
  );

  // FSM state register.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_valid)  state_d = BUSY;
      BUSY:    if (last_step) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, iteration counter, multiply datapath and result registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      op_q       <= OP_MUL;
      rd_q       <= '0;
      rd_out_q   <= '0;
      res_q      <= '0;
      mcand_q    <= '0;
      prod_q     <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q       <= op_in;
        rd_q       <= i_rd;
        mcand_q    <= a_mag;
        prod_q     <= {{XLEN{1'b0}}, b_mag};
        cnt_q      <= '0;
        neg_q      <= a_neg ^ b_neg;
        rem_neg_q  <= a_neg;
        div_zero_q <= (i_rs2_val == '0);
      end else if (state_q == BUSY) begin
        cnt_q <= cnt_q + CNT_W'(1);
`ifndef MULDIV_FAST_MUL_EN
        if (!op_q[2]) prod_q <= mul_final;
`endif
      end
      if (last_step) begin
        res_q    <= result_d;
        rd_out_q <= rd_q;
      end
    end
  end

  assign o_ready          = (state_q == IDLE);
  assign o_done           = (state_q == DONE);
  assign rd_write_control = o_done && (rd_out_q != 5'd0);
  assign rd               = rd_out_q;
  assign rd_write_val     = res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: reset values, every op class, divide-by-zero,
// signed overflow, rd=0 write suppression, input toggling while busy,
// back-to-back requests and reset in the middle of a divide.
module tb_muldiv_unit;
  import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 32;
`endif
  localparam int DIV_LAT = 32;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic [2:0]  i_op = '0;
  logic [31:0] i_rs1_val = '0;
  logic [31:0] i_rs2_val = '0;
  logic [4:0]  i_rd = '0;
  logic        o_ready, o_done, rd_write_control;
  logic [4:0]  rd;
  logic [31:0] rd_write_val;

  int total = 0;
  int bad   = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_valid          (i_valid),
    .i_op             (i_op),
    .i_rs1_val        (i_rs1_val),
    .i_rs2_val        (i_rs2_val),
    .i_rd             (i_rd),
    .o_ready          (o_ready),
    .o_done           (o_done),
    .rd               (rd),
    .rd_write_control (rd_write_control),
    .rd_write_val     (rd_write_val)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait for its completion pulse, check latency, result,
  // destination, strobe count, and the return to IDLE on the following edge.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rdi,
                        input logic [31:0] exp, input int exp_lat, input bit scramble);
    int lat;
    int strobes;
    lat = 0;
    strobes = 0;
    @(negedge i_clk);
    check({tag, ":ready"}, 32'(o_ready), 32'd1);
    i_valid = 1'b1; i_op = op; i_rs1_val = a; i_rs2_val = b; i_rd = rdi;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (scramble) begin
        i_valid = 1'b1; i_op = ~op; i_rs1_val = $urandom; i_rs2_val = $urandom;
        i_rd = 5'($urandom);
      end
      @(posedge i_clk); #1;
      if (rd_write_control) strobes++;
      if (o_done) begin
        lat = k;
        break;
      end
    end
    i_valid = 1'b0;
    check({tag, ":latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ":value"}, rd_write_val, exp);
    check({tag, ":rd"}, 32'(rd), 32'(rdi));
    check({tag, ":strobes"}, 32'(strobes), (rdi != 5'd0) ? 32'd1 : 32'd0);
    check({tag, ":busy_not_ready"}, 32'(o_ready), 32'd0);
    @(posedge i_clk); #1;
    check({tag, ":done_one_cycle"}, 32'(o_done), 32'd0);
    check({tag, ":strobe_off"}, 32'(rd_write_control), 32'd0);
    check({tag, ":idle_ready"}, 32'(o_ready), 32'd1);
    check({tag, ":value_held"}, rd_write_val, exp);
  endtask

  initial begin
    int events;
    #1;
    check("rst:ready", 32'(o_ready), 32'd1);
    check("rst:done", 32'(o_done), 32'd0);
    check("rst:rd", 32'(rd), 32'd0);
    check("rst:wctl", 32'(rd_write_control), 32'd0);
    check("rst:val", rd_write_val, 32'd0);
    #10;
    @(negedge i_clk);
    i_rst = 1'b0;

    run_op("mul_neg",   OP_MUL,    32'd7,        32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, MUL_LAT, 1'b0);
    run_op("mulhu_max", OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 32'hFFFFFFFE, MUL_LAT, 1'b0);
    run_op("mulh_m1",   OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'h00000000, MUL_LAT, 1'b0);
    run_op("mulhsu_m1", OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFF, MUL_LAT, 1'b0);
    run_op("div_neg",   OP_DIV,    32'hFFFFFFF9, 32'd2,        5'd4, 32'hFFFFFFFD, DIV_LAT, 1'b0);
    run_op("rem_neg",   OP_REM,    32'hFFFFFFF9, 32'd2,        5'd6, 32'hFFFFFFFF, DIV_LAT, 1'b0);
    run_op("divu_z",    OP_DIVU,   32'd5,        32'd0,        5'd8, 32'hFFFFFFFF, DIV_LAT, 1'b0);
    run_op("remu_z",    OP_REMU,   32'd5,        32'd0,        5'd9, 32'd5,        DIV_LAT, 1'b0);
    run_op("div_negz",  OP_DIV,    32'hFFFFFFF9, 32'd0,        5'd10, 32'hFFFFFFFF, DIV_LAT, 1'b0);
    run_op("rem_negz",  OP_REM,    32'hFFFFFFF9, 32'd0,        5'd11, 32'hFFFFFFF9, DIV_LAT, 1'b0);
    run_op("div_ovf",   OP_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, DIV_LAT, 1'b0);
    run_op("rem_ovf",   OP_REM,    32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h00000000, DIV_LAT, 1'b0);
    run_op("mul_rd0",   OP_MUL,    32'd3,        32'd4,        5'd0, 32'd12,       MUL_LAT, 1'b1);
    run_op("divu_scr",  OP_DIVU,   32'd100,      32'd7,        5'd31, 32'd14,      DIV_LAT, 1'b1);

    // Reset asserted between clock edges at iteration 10 of a divide.
    @(negedge i_clk);
    i_valid = 1'b1; i_op = OP_DIVU; i_rs1_val = 32'd1000; i_rs2_val = 32'd3; i_rd = 5'd9;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (10) @(posedge i_clk);
    #2;
    i_rst = 1'b1;
    #1;
    check("midrst:ready", 32'(o_ready), 32'd1);
    check("midrst:done", 32'(o_done), 32'd0);
    check("midrst:rd", 32'(rd), 32'd0);
    check("midrst:wctl", 32'(rd_write_control), 32'd0);
    check("midrst:val", rd_write_val, 32'd0);
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    events = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge i_clk); #1;
      if (o_done || rd_write_control) events++;
    end
    check("midrst:no_completion", 32'(events), 32'd0);
    run_op("divu_after_rst", OP_DIVU, 32'd100, 32'd7, 5'd7, 32'd14, DIV_LAT, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter: XLEN, 32, operand/result width (only 32 supported).
REQ-002 SHALL have port: i_clk  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: i_rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port: i_valid  in  1  request present.
REQ-005 SHALL have port: i_op  in  3  RV32M funct3 (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU).
REQ-006 SHALL have ports: i_rs1_val  in  32  and  i_rs2_val  in  32, operands from register-file read ports.
REQ-007 SHALL have port: i_rd  in  5  destination register index.
REQ-008 SHALL have port: o_ready  out  1  unit can accept a request.
REQ-009 SHALL have port: o_done  out  1  one-cycle completion pulse.
REQ-010 SHALL have ports: rd  out  5,  rd_write_control  out  1,  rd_write_val  out  32, which drive the register-file write port directly.

Function
REQ-011 SHALL have states IDLE, BUSY, DONE; accept only on an edge with i_valid=1 and o_ready=1; o_ready=1 only in IDLE.
REQ-012 SHALL latch i_op, operands and i_rd at the accepting edge; input changes while BUSY/DONE have no effect.
REQ-013 SHALL go IDLE->BUSY on accept, run one iteration per edge for 32 edges, enter DONE on the 32nd, and return DONE->IDLE on the next edge.
REQ-014 SHALL assert o_done for exactly the one DONE cycle, 32 edges after the accepting edge (divide always, multiply without the macro).
REQ-015 SHALL assert rd_write_control in DONE only when latched rd != 0; o_done pulses regardless.
REQ-016 SHALL hold rd and rd_write_val valid throughout DONE, and keep them at the last result otherwise.
REQ-017 SHALL have MUL return the low 32 bits of the product; MULH, MULHSU and MULHU return the high 32 bits of the 64-bit signed x signed, signed x unsigned and unsigned x unsigned products respectively.
REQ-018 SHALL perform signed divide on magnitudes and correct sign at the end: quotient rounds toward zero, remainder takes the dividend's sign.
REQ-019 SHALL on divide-by-zero return quotient 0xFFFFFFFF (DIV and DIVU) and remainder = dividend, with unchanged latency.
REQ-020 SHALL on DIV overflow (0x80000000 / 0xFFFFFFFF) return quotient 0x80000000 and remainder 0, with unchanged latency.
REQ-021 SHALL allow back-to-back operation: a new accept is possible on the edge after DONE (IDLE cycle required).

Reset
REQ-022 SHALL on i_rst=1, immediately and independent of i_clk, force IDLE, o_ready=1, o_done=0, rd=0, rd_write_control=0, rd_write_val=0, and clear counter and datapath.
REQ-023 SHALL abort any in-flight operation on reset mid-BUSY or mid-DONE, with no write strobe issued.

Configuration
REQ-024 SHALL, with MULDIV_FAST_MUL_EN defined, compute all multiply ops in one step: BUSY lasts one edge, and o_done asserts 1 edge after the accepting edge.
REQ-025 SHALL, without MULDIV_FAST_MUL_EN, use the iterative 32-edge shift-add multiplier; divide latency is identical in both builds.

Structure
REQ-026 SHALL place XLEN, the op enum (funct3 encodings) and the state enum in package muldiv_pkg.
REQ-027 SHALL implement the restoring divider as sub-module muldiv_div_iter; multiply, sign handling and FSM stay in muldiv_unit.

Verification
REQ-028 SHALL cover: MUL 7 x 0xFFFFFFFD, rd=5 -> rd_write_val 0xFFFFFFEB with strobe 32 edges after accept (1 edge with MULDIV_FAST_MUL_EN).
REQ-029 SHALL cover: operands 0xFFFFFFFF, 0xFFFFFFFF -> MULHU 0xFFFFFFFE, MULH 0x00000000, MULHSU 0xFFFFFFFF.
REQ-030 SHALL cover: DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
REQ-031 SHALL cover: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
REQ-032 SHALL cover: reset pulsed at iteration 10 of DIVU -> all outputs 0, o_ready=1, no strobe; next DIVU 100/7 -> 14.
REQ-033 SHALL cover: MUL 3 x 4 with rd=0 -> o_done pulses once and rd_write_control stays 0; inputs toggled while BUSY -> result unchanged.
